// File: rtl/fc784_tile_sched_if.sv
// fc784_tile_sched_if
//
// Bundle between the FC-layer tile scheduler, its controller and the shared PE tile.
//   master : scheduler view (consumes start/tile_done/tile_psum, drives everything else)
//   slave  : environment view (controller + PE tile), the mirror image of master
//
// Signals:
//   start       layer start request
//   tile_done   PE tile finished the current pass
//   tile_psum   PE tile result, lane j at [j*W +: W]
//   tile_start  one-cycle tile launch pulse
//   tile_idx    current tile index
//   row_base    first weight-matrix row of the current tile
//   tile_rows   row count of the current tile
//   busy        layer pass in progress
//   psum        accumulated result, same packing as tile_psum
//   finish      one-cycle pulse, psum final while high
//   timeout_err sticky tile-timeout flag
interface fc784_tile_sched_if #(
    parameter int N_OUT = 64,
    parameter int W     = 16
);
    logic                   start;
    logic                   tile_done;
    logic [N_OUT*W-1:0]     tile_psum;
    logic                   tile_start;
    logic [3:0]             tile_idx;
    logic [9:0]             row_base;
    logic [6:0]             tile_rows;
    logic                   busy;
    logic [N_OUT*W-1:0]     psum;
    logic                   finish;
    logic                   timeout_err;

    modport master (
        input  start, tile_done, tile_psum,
        output tile_start, tile_idx, row_base, tile_rows, busy, psum, finish, timeout_err
    );

    modport slave (
        output start, tile_done, tile_psum,
        input  tile_start, tile_idx, row_base, tile_rows, busy, psum, finish, timeout_err
    );
endinterface

// File: rtl/fc784_tile_sched.sv
// fc784_tile_sched
//
// Sequences one shared 64x64 PE tile over the 784->64 fully-connected layer: 12 full
// 64-row tiles followed by one 16-row tile. For each tile it issues the index and row
// window, pulses tile_start, waits for tile_done and adds the 64 returned lanes into a
// wrapping per-lane accumulator. After the last tile the sum is copied to psum and
// finish pulses for one cycle. A tile that stays silent for TIMEOUT cycles aborts the
// pass and raises the sticky timeout_err.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   bus   fc784_tile_sched_if.master, all handshake/data signals (see interface file)
//
// All outputs are registered; TIMEOUT must be at least 2.
module fc784_tile_sched #(
    parameter int N_IN    = 784,
    parameter int N_OUT   = 64,
    parameter int TILE    = 64,
    parameter int W       = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    fc784_tile_sched_if.master    bus
);

    localparam int NUM_TILES = (N_IN + TILE - 1) / TILE;
    localparam int LAST_ROWS = N_IN - (NUM_TILES - 1) * TILE;
    localparam int CW        = $clog2(TIMEOUT) + 1;
    localparam logic [3:0] LAST_IDX = 4'(NUM_TILES - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e               state_q, state_d;
    logic [3:0]           tile_idx_q, tile_idx_d;
    logic [9:0]           row_base_q, row_base_d;
    logic [6:0]           tile_rows_q, tile_rows_d;
    logic                 tile_start_q, tile_start_d;
    logic                 busy_q, busy_d;
    logic                 finish_q, finish_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [CW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [N_OUT*W-1:0]   acc_q, acc_d;
    logic [N_OUT*W-1:0]   psum_q, psum_d;
    logic [N_OUT*W-1:0]   lane_sum;

    // Independent W-bit lanes; the slice width drops each lane's carry so sums wrap.
    always_comb begin
        lane_sum = '0;
        for (int j = 0; j < N_OUT; j++) begin
            lane_sum[j*W +: W] = acc_q[j*W +: W] + bus.tile_psum[j*W +: W];
        end
    end

    always_comb begin
        state_d       = state_q;
        tile_idx_d    = tile_idx_q;
        timeout_err_d = timeout_err_q;
        wait_cnt_d    = wait_cnt_q;
        acc_d         = acc_q;
        psum_d        = psum_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d       = StIssue;
                    tile_idx_d    = '0;
                    timeout_err_d = 1'b0;
                    acc_d         = '0;
                    psum_d        = '0;
                end
            end
            StIssue: begin
                // The ISSUE cycle is wait cycle 0, so the first WAIT cycle sees 1 and the
                // abort lands TIMEOUT cycles after tile_start.
                wait_cnt_d = CW'(1);
                state_d    = StWait;
            end
            StWait: begin
                // A response in the last allowed cycle still wins over the abort.
                if (bus.tile_done) begin
                    acc_d = lane_sum;
                    if (tile_idx_q == LAST_IDX) begin
                        psum_d  = lane_sum;
                        state_d = StDone;
                    end else begin
                        tile_idx_d = tile_idx_q + 4'd1;
                        state_d    = StIssue;
                    end
                end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered copies of the next state so they line up with it.
        tile_start_d = (state_d == StIssue);
        busy_d       = (state_d != StIdle);
        finish_d     = (state_d == StDone);
        row_base_d   = 10'(32'(tile_idx_d) * TILE);
        tile_rows_d  = (tile_idx_d == LAST_IDX) ? 7'(LAST_ROWS) : 7'(TILE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            tile_idx_q    <= '0;
            row_base_q    <= '0;
            tile_rows_q   <= 7'(TILE);
            tile_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            finish_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            wait_cnt_q    <= '0;
            acc_q         <= '0;
            psum_q        <= '0;
        end else begin
            state_q       <= state_d;
            tile_idx_q    <= tile_idx_d;
            row_base_q    <= row_base_d;
            tile_rows_q   <= tile_rows_d;
            tile_start_q  <= tile_start_d;
            busy_q        <= busy_d;
            finish_q      <= finish_d;
            timeout_err_q <= timeout_err_d;
            wait_cnt_q    <= wait_cnt_d;
            acc_q         <= acc_d;
            psum_q        <= psum_d;
        end
    end

    assign bus.tile_start  = tile_start_q;
    assign bus.tile_idx    = tile_idx_q;
    assign bus.row_base    = row_base_q;
    assign bus.tile_rows   = tile_rows_q;
    assign bus.busy        = busy_q;
    assign bus.finish      = finish_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.psum        = psum_q;

endmodule

// File: tb/tb_fc784_tile_sched.sv
// Bench for fc784_tile_sched: instance A uses TIMEOUT=1024, instance B uses TIMEOUT=8.
// Both share the stimulus; sel chooses whose outputs are observed.
module tb_fc784_tile_sched;

    logic clk;
    logic rst;
    logic start;
    logic tile_done;
    logic [1023:0] tile_psum;
    logic sel;

    fc784_tile_sched_if #(.N_OUT(64), .W(16)) bus_a ();
    fc784_tile_sched_if #(.N_OUT(64), .W(16)) bus_b ();

    fc784_tile_sched #(.N_IN(784), .N_OUT(64), .TILE(64), .W(16), .TIMEOUT(1024)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    fc784_tile_sched #(.N_IN(784), .N_OUT(64), .TILE(64), .W(16), .TIMEOUT(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    assign bus_a.start     = start;
    assign bus_a.tile_done = tile_done;
    assign bus_a.tile_psum = tile_psum;
    assign bus_b.start     = start;
    assign bus_b.tile_done = tile_done;
    assign bus_b.tile_psum = tile_psum;

    logic          s_tile_start, s_busy, s_finish, s_timeout_err;
    logic [3:0]    s_tile_idx;
    logic [9:0]    s_row_base;
    logic [6:0]    s_tile_rows;
    logic [1023:0] s_psum;

    always_comb begin
        s_tile_start  = sel ? bus_b.tile_start  : bus_a.tile_start;
        s_tile_idx    = sel ? bus_b.tile_idx    : bus_a.tile_idx;
        s_row_base    = sel ? bus_b.row_base    : bus_a.row_base;
        s_tile_rows   = sel ? bus_b.tile_rows   : bus_a.tile_rows;
        s_busy        = sel ? bus_b.busy        : bus_a.busy;
        s_psum        = sel ? bus_b.psum        : bus_a.psum;
        s_finish      = sel ? bus_b.finish      : bus_a.finish;
        s_timeout_err = sel ? bus_b.timeout_err : bus_a.timeout_err;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Results of the most recent pass.
    logic [1023:0] gold_vec;
    logic [1023:0] psum_fin;
    int fin_cyc, n_starts, n_fin, to_cyc, dead_ts;
    logic to_busy;

    typedef struct {
        int mode;   // 0: a + b*tile + c*lane, 1: signed-wrap pattern
        int a;
        int b;
        int c;
        int d;      // tile response latency
        int e0;     // expected lane 0
        int eb;     // expected lane j>0 = eb + j*es (mod 2^16)
        int es;
        int efin;   // expected finish cycle after the start edge
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_psum(input string name, input logic [1023:0] act,
                            input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int j = 0; j < 64; j++) begin
                if (act[j*16 +: 16] !== exp[j*16 +: 16]) begin
                    $display("FAIL %s lane %0d: got %h want %h", name, j,
                             act[j*16 +: 16], exp[j*16 +: 16]);
                    break;
                end
            end
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_tile_start"}, 32'(s_tile_start), 32'd0);
        chk({name, "_tile_idx"}, 32'(s_tile_idx), 32'd0);
        chk({name, "_row_base"}, 32'(s_row_base), 32'd0);
        chk({name, "_tile_rows"}, 32'(s_tile_rows), 32'd64);
        chk({name, "_busy"}, 32'(s_busy), 32'd0);
        chk({name, "_finish"}, 32'(s_finish), 32'd0);
        chk({name, "_timeout_err"}, 32'(s_timeout_err), 32'd0);
        chk_psum({name, "_psum"}, s_psum, '0);
    endtask

    function automatic logic [15:0] tile_val(input int mode, input int a, input int b,
                                             input int c, input int t, input int j);
        if (mode == 0) return 16'(a + b * t + c * j);
        if (t == 0 && j == 0) return 16'h7fff;
        if (t == 1 && j == 0) return 16'h0001;
        return 16'h0000;
    endfunction

    function automatic logic [1023:0] exp_vec(input int e0, input int eb, input int es);
        logic [1023:0] r;
        for (int j = 0; j < 64; j++) begin
            r[j*16 +: 16] = (j == 0) ? 16'(e0) : 16'(eb + j * es);
        end
        return r;
    endfunction

    // One layer pass with a cycle-accurate tile responder. dead_tile never answers;
    // rst_tile gets a one-edge reset in its first WAIT cycle followed by a late tile_done.
    task automatic do_pass(input int mode, input int a, input int b, input int c, input int d,
                           input bit rnd, input bit noise, input int dead_tile,
                           input int rst_tile);
        int cyc, wait_c, cur, lat;
        bit ended, rst_pend;
        logic [15:0] v;
        gold_vec = '0;
        psum_fin = '0;
        fin_cyc  = -1;
        n_starts = 0;
        n_fin    = 0;
        to_cyc   = -1;
        dead_ts  = -1;
        to_busy  = 1'b1;
        ended    = 1'b0;
        rst_pend = 1'b0;
        wait_c   = 0;
        cur      = -1;
        if (noise) begin
            tile_done = 1'b1;
            tile_psum = {64{16'h5a5a}};
            repeat (3) @(posedge clk);
            #1;
            chk("idle_noise_busy", 32'(s_busy), 32'd0);
            chk("idle_noise_tile_start", 32'(s_tile_start), 32'd0);
            tile_done = 1'b0;
            tile_psum = '0;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        chk_psum("start_clears_psum", s_psum, '0);
        chk("start_busy", 32'(s_busy), 32'd1);
        chk("start_timeout_err_clear", 32'(s_timeout_err), 32'd0);
        while (!ended && cyc < 320) begin
            tile_done = 1'b0;
            tile_psum = '0;
            start     = (noise && cyc >= 10 && cyc <= 12);
            if (fin_cyc >= 0) begin
                chk("busy_after_done", 32'(s_busy), 32'd0);
                chk("finish_single_cycle", 32'(s_finish), 32'd0);
                chk_psum("psum_hold_after_finish", s_psum, gold_vec);
                ended = 1'b1;
            end else if (to_cyc >= 0 && cyc >= to_cyc + 4) begin
                ended = 1'b1;
            end else if (rst_pend) begin
                rst = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b1;
                chk_reset("mid_rst");
                tile_done = 1'b1;
                for (int j = 0; j < 64; j++) tile_psum[j*16 +: 16] = tile_val(mode, a, b, c, cur, j);
                @(posedge clk);
                #1;
                tile_done = 1'b0;
                tile_psum = '0;
                chk("late_done_tile_start", 32'(s_tile_start), 32'd0);
                chk("late_done_busy", 32'(s_busy), 32'd0);
                chk("late_done_tile_idx", 32'(s_tile_idx), 32'd0);
                chk_psum("late_done_psum", s_psum, '0);
                ended = 1'b1;
            end else begin
                if (s_tile_start) begin
                    n_starts++;
                    cur = int'(s_tile_idx);
                    chk("tile_idx_seq", 32'(s_tile_idx), 32'(n_starts - 1));
                    chk("row_base_seq", 32'(s_row_base), 32'((n_starts - 1) * 64));
                    chk("tile_rows_seq", 32'(s_tile_rows), (n_starts == 13) ? 32'd16 : 32'd64);
                    lat = rnd ? int'($urandom_range(20, 1)) : d;
                    if (cur == dead_tile) dead_ts = cyc;
                    rst_pend = (cur == rst_tile);
                    wait_c = (cur == dead_tile || cur == rst_tile) ? 0 : lat;
                    if (noise) begin
                        tile_done = 1'b1;
                        tile_psum = {64{16'h0bad}};
                    end
                end else if (wait_c > 0) begin
                    wait_c--;
                    if (wait_c == 0) begin
                        tile_done = 1'b1;
                        for (int j = 0; j < 64; j++) begin
                            v = tile_val(mode, a, b, c, cur, j);
                            tile_psum[j*16 +: 16] = v;
                            gold_vec[j*16 +: 16]  = gold_vec[j*16 +: 16] + v;
                        end
                    end
                end
                if (s_finish) begin
                    n_fin++;
                    fin_cyc  = cyc;
                    psum_fin = s_psum;
                    chk("busy_in_done", 32'(s_busy), 32'd1);
                    chk_psum("psum_golden", s_psum, gold_vec);
                end
                if (s_timeout_err && to_cyc < 0) begin
                    to_cyc  = cyc;
                    to_busy = s_busy;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!ended) begin
            checks++;
            errors++;
            $display("FAIL pass_budget: pass still open after %0d cycles, want finish or abort", cyc);
        end
        start     = 1'b0;
        tile_done = 1'b0;
        tile_psum = '0;
    endtask

    initial begin
        vecs[0] = '{0, 1, 0, 0, 1, 13, 13, 0, 27};
        vecs[1] = '{0, 'h1000, 'h100, 1, 2, 'h1e00, 'h1e00, 13, 40};
        vecs[2] = '{0, 'hffff, 0, 'hfffe, 3, 'hfff3, 'hfff3, 'hffe6, 53};
        vecs[3] = '{1, 0, 0, 0, 1, 'h8000, 0, 0, 27};
        vecs[4] = '{0, 'h7000, 'h10, 'h100, 5, 'hb4e0, 'hb4e0, 'hd00, 79};

        sel       = 1'b0;
        rst       = 1'b0;
        start     = 1'b0;
        tile_done = 1'b0;
        tile_psum = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back passes: each start lands in the first IDLE cycle after finish.
        for (int i = 0; i < 5; i++) begin
            do_pass(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, 1'b0, 1'b0, -1, -1);
            chk($sformatf("v%0d_tile_starts", i), 32'(n_starts), 32'd13);
            chk($sformatf("v%0d_finish_count", i), 32'(n_fin), 32'd1);
            chk($sformatf("v%0d_finish_cycle", i), 32'(fin_cyc), 32'(vecs[i].efin));
            chk_psum($sformatf("v%0d_psum", i), psum_fin,
                     exp_vec(vecs[i].e0, vecs[i].eb, vecs[i].es));
        end

        repeat (5) @(posedge clk);
        #1;
        chk_psum("psum_idle_hold", s_psum, exp_vec(vecs[4].e0, vecs[4].eb, vecs[4].es));

        // Random latency with spurious tile_done and mid-pass start.
        do_pass(0, 'h0321, 'h0777, 'h0013, 1, 1'b1, 1'b1, -1, -1);
        chk("noise_tile_starts", 32'(n_starts), 32'd13);
        chk("noise_finish_count", 32'(n_fin), 32'd1);

        // Reset during WAIT of tile 7, then a clean pass with no residue.
        do_pass(0, 'h0500, 3, 1, 2, 1'b0, 1'b0, -1, 7);
        chk("rst_tile_starts", 32'(n_starts), 32'd8);
        chk("rst_finish_count", 32'(n_fin), 32'd0);
        do_pass(0, 2, 0, 0, 1, 1'b0, 1'b0, -1, -1);
        chk("post_rst_finish_cycle", 32'(fin_cyc), 32'd27);
        chk_psum("post_rst_psum", psum_fin, exp_vec(26, 26, 0));

        // Timeout on the TIMEOUT=8 instance.
        sel = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk_reset("reset_b");
        do_pass(0, 1, 0, 0, 1, 1'b0, 1'b0, 5, -1);
        chk("to_tile_starts", 32'(n_starts), 32'd6);
        chk("to_err_cycle", 32'(to_cyc), 32'(dead_ts + 8));
        chk("to_busy", 32'(to_busy), 32'd0);
        chk("to_no_finish", 32'(n_fin), 32'd0);
        chk("to_err_sticky", 32'(s_timeout_err), 32'd1);
        chk_psum("to_psum", s_psum, '0);
        // Longest accepted latency (TIMEOUT-1) after the abort.
        do_pass(0, 'h100, 1, 0, 7, 1'b0, 1'b0, -1, -1);
        chk("after_to_finish_count", 32'(n_fin), 32'd1);
        chk("after_to_finish_cycle", 32'(fin_cyc), 32'd105);
        chk("after_to_err", 32'(s_timeout_err), 32'd0);
        chk_psum("after_to_psum", psum_fin, exp_vec('hd4e, 'hd4e, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
